gen3_packet_sequencer: RTL

Sequences the per-byte framing markers produced by the Gen3 packet-identifier datapath into whole-packet descriptors. It walks the eight byte lanes of each 64-bit word in order and tracks an open TLP or DLLP across word boundaries. On each packet boundary it emits a descriptor with type, length, nullified and error flags into a small descriptor FIFO with a valid/ready output. It sits directly after the datapath and feeds the downstream packet consumers (TLP/DLLP handlers).

---
 rtl/gen3_packet_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gen3_packet_sequencer.sv
// Gen3 packet sequencer: turns per-lane framing markers into packet
// descriptors and queues them in a small FIFO with valid/ready output.
module gen3_packet_sequencer #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       valid_d,
  input  logic [7:0]       tlpstart,
  input  logic [7:0]       tlpend,
  input  logic [7:0]       tlpedb,
  input  logic [7:0]       dlpstart,
  input  logic [7:0]       dlpend,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic             desc_type,
  output logic [LEN_W-1:0] desc_len,
  output logic             desc_null,
  output logic             desc_err,
  output logic             in_packet,
  output logic             framing_err,
  output logic [7:0]       err_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = LEN_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    IN_TLP,
    IN_DLP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    push0, push1;
  logic [2:0]       npush;
  logic             word_err;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, free;
  logic [1:0]       n_acc;
  logic             pop;

  always_comb begin : walk
    logic [4:0]    mk;
    logic          pv;
    logic [DW-1:0] pd;
    state_d  = state_q;
    len_d    = len_q;
    push0    = '0;
    push1    = '0;
    npush    = '0;
    word_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pv = 1'b0;
      pd = '0;
      // mk = {tlpstart, tlpend, tlpedb, dlpstart, dlpend}
      mk = {tlpstart[i], tlpend[i], tlpedb[i],
            dlpstart[i], dlpend[i]};
      if (valid_d[i]) begin
        if ((mk & (mk - 5'd1)) != 5'd0) begin
          word_err = 1'b1;
          mk       = '0;
        end
        unique case (state_d)
          IDLE: begin
            if (mk[4]) begin
              state_d = IN_TLP;
              len_d   = {{(LEN_W-1){1'b0}}, 1'b1};
            end else if (mk[1]) begin
              state_d = IN_DLP;
              len_d   = {{(LEN_W-1){1'b0}}, 1'b1};
            end else if (mk != 5'd0) begin
              word_err = 1'b1;
            end
          end
          IN_TLP, IN_DLP: begin
            if (mk[4] | mk[1]) begin
              // abort: close with the bytes seen so far
              word_err = 1'b1;
              pv       = 1'b1;
              pd       = {state_d == IN_DLP, len_d, 1'b0, 1'b1};
              state_d  = mk[4] ? IN_TLP : IN_DLP;
              len_d    = {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
              if (len_d != '1) len_d = len_d + 1'b1;
              if (state_d == IN_TLP && (mk[3] | mk[2])) begin
                pv      = 1'b1;
                pd      = {1'b0, len_d, mk[2], 1'b0};
                state_d = IDLE;
              end else if (state_d == IN_DLP && mk[0]) begin
                pv      = 1'b1;
                pd      = {1'b1, len_d, 1'b0, 1'b0};
                state_d = IDLE;
              end else if (mk != 5'd0) begin
                word_err = 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (pv) begin
          if (npush == 3'd0) push0 = pd;
          else if (npush == 3'd1) push1 = pd;
          npush = npush + 3'd1;
        end
      end
    end
  end

  assign pop  = desc_valid & desc_ready;
  assign free = (AW+1)'(DEPTH) - count + {{AW{1'b0}}, pop};

  always_comb begin
    n_acc = 2'd0;
    if (npush != 3'd0 && free != '0)
      n_acc = 2'd1;
    if (npush > 3'd1 && free > (AW+1)'(1))
      n_acc = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      framing_err <= 1'b0;
      err_count   <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      framing_err <= word_err;
      if (word_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if ({1'b0, n_acc} != npush)
        overflow <= 1'b1;
      wr_ptr <= wr_ptr + AW'(n_acc);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(n_acc)
              - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (n_acc != 2'd0) mem[wr_ptr] <= push0;
      if (n_acc == 2'd2) mem[wr_ptr + AW'(1)] <= push1;
    end
  end

  assign desc_valid = (count != '0);
  assign in_packet  = (state_q != IDLE);
  assign {desc_type, desc_len, desc_null, desc_err} =
    desc_valid ? mem[rd_ptr] : '0;

endmodule
